// File: rtl/mod_inv_binary.sv
// Binary extended-Euclid modular inverse: o_result = a^-1 mod p for odd p >= 3.
// Optional CONST_TIME padding makes every valid run take the same number of cycles.
module mod_inv_binary #(
    parameter int W          = 256,
    parameter bit CONST_TIME = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_p,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_result,
    output logic         o_error
);
    localparam int XW = W + 1;
    localparam int CW = $clog2(4 * W) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(4 * W);
    localparam logic [XW-1:0] ONE     = XW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOOP,
        S_PAD,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [XW-1:0] r_u, r_v, r_x1, r_x2;
    logic [XW-1:0] w_u_nxt, w_v_nxt, w_x1_nxt, w_x2_nxt;
    logic [W-1:0]  r_p, w_p_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0]  r_result, w_result_nxt;
    logic          r_error, w_error_nxt;
    logic [XW-1:0] w_p_ext;

    assign w_p_ext = {1'b0, r_p};

    // x/2 mod m for odd m: odd x is made even by adding m first (fits in W+1 bits).
    function automatic logic [XW-1:0] halve_mod(input logic [XW-1:0] x, input logic [XW-1:0] m);
        return x[0] ? ((x + m) >> 1) : (x >> 1);
    endfunction

    function automatic logic [XW-1:0] sub_mod(input logic [XW-1:0] x, input logic [XW-1:0] y,
                                              input logic [XW-1:0] m);
        return (x >= y) ? (x - y) : (x + m - y);
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_u_nxt      = r_u;
        w_v_nxt      = r_v;
        w_x1_nxt     = r_x1;
        w_x2_nxt     = r_x2;
        w_p_nxt      = r_p;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_error_nxt  = r_error;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_u_nxt      = {1'b0, i_a};
                    w_v_nxt      = {1'b0, i_p};
                    w_x1_nxt     = ONE;
                    w_x2_nxt     = '0;
                    w_p_nxt      = i_p;
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_error_nxt  = 1'b0;
                    w_state_nxt  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!r_p[0] || (r_p < W'(3)) || (r_u == '0) || (r_u >= w_p_ext)) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_LOOP;
                end
            end
            S_LOOP: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if ((r_u == ONE) || (r_v == ONE)) begin
                    w_result_nxt = (r_u == ONE) ? r_x1[W-1:0] : r_x2[W-1:0];
                    w_state_nxt  = CONST_TIME ? S_PAD : S_DONE;
                end else if ((r_u == '0) || (r_v == '0)) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = CONST_TIME ? S_PAD : S_DONE;
                end else if (r_cnt == MAX_CNT) begin
                    // Unreachable for legal operands; guards against a stuck loop.
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (!r_u[0]) begin
                    w_u_nxt  = r_u >> 1;
                    w_x1_nxt = halve_mod(r_x1, w_p_ext);
                end else if (!r_v[0]) begin
                    w_v_nxt  = r_v >> 1;
                    w_x2_nxt = halve_mod(r_x2, w_p_ext);
                end else if (r_u >= r_v) begin
                    w_u_nxt  = r_u - r_v;
                    w_x1_nxt = sub_mod(r_x1, r_x2, w_p_ext);
                end else begin
                    w_v_nxt  = r_v - r_u;
                    w_x2_nxt = sub_mod(r_x2, r_x1, w_p_ext);
                end
            end
            S_PAD: begin
                if (r_cnt == MAX_CNT) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_error  <= w_error_nxt;
        end
    end

    // NOTE: working registers are always loaded on an accepted start, so they need no reset.
    always_ff @(posedge i_clk) begin
        r_u  <= w_u_nxt;
        r_v  <= w_v_nxt;
        r_x1 <= w_x1_nxt;
        r_x2 <= w_x2_nxt;
        r_p  <= w_p_nxt;
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_error  = r_error;

endmodule
